// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root: restoring digit recurrence, one root bit per cycle,
// tag carry-through and flush. Define FP_SQRT_RM_EN to add the in_rm dynamic rounding-mode port.
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_operand,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef FP_SQRT_RM_EN
    input  logic [2:0]             in_rm,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [1:0]             out_flags
);

    localparam int XLEN = 1 + EXP_W + MAN_W;
    localparam int RW   = MAN_W + 2;
    localparam int RADW = 2 * RW;
    localparam int PRW  = MAN_W + 4;
    localparam int CW   = $clog2(RW);
    localparam logic [EXP_W-1:0] BIAS_V = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [XLEN-1:0]  QNAN_V = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(RW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [RADW-1:0] rad_r;
    logic [PRW-1:0]  rem_r;
    logic [RW-1:0]   root_r;
    logic [CW-1:0]   cnt_r;
    logic [EXP_W-1:0] exp_r;
    logic [TAG_W-1:0] tag_r;
    logic [2:0]      rm_s;

`ifdef FP_SQRT_RM_EN
    logic [2:0] rm_r;
    logic       rm_bad_s;
    assign rm_s     = rm_r;
    assign rm_bad_s = in_rm[2] & (in_rm[1] | in_rm[0]);
`else
    logic       rm_bad_s;
    assign rm_s     = 3'b000;
    assign rm_bad_s = 1'b0;
`endif

    logic              op_sign_s;
    logic [EXP_W-1:0]  op_exp_s;
    logic [MAN_W-1:0]  op_frac_s;
    assign op_sign_s = in_operand[XLEN-1];
    assign op_exp_s  = in_operand[XLEN-2:MAN_W];
    assign op_frac_s = in_operand[MAN_W-1:0];

    logic              spec_s;
    logic [XLEN-1:0]   spec_res_s;
    logic [1:0]        spec_flags_s;

    // Classify the incoming operand and form the special-path result
    always_comb begin
        spec_s       = 1'b1;
        spec_res_s   = QNAN_V;
        spec_flags_s = 2'b10;
        if (rm_bad_s) begin
            spec_res_s   = QNAN_V;
            spec_flags_s = 2'b10;
        end else if ((&op_exp_s) && (|op_frac_s)) begin
            spec_res_s   = QNAN_V;
            spec_flags_s = {~op_frac_s[MAN_W-1], 1'b0};
        end else if (~|op_exp_s) begin
            spec_res_s   = {op_sign_s, {(XLEN-1){1'b0}}};
            spec_flags_s = 2'b00;
        end else if (op_sign_s) begin
            spec_res_s   = QNAN_V;
            spec_flags_s = 2'b10;
        end else if (&op_exp_s) begin
            spec_res_s   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_s = 2'b00;
        end else begin
            spec_s       = 1'b0;
            spec_res_s   = {XLEN{1'b0}};
            spec_flags_s = 2'b00;
        end
    end

    // (E + bias) / 2 equals floor(e/2) + bias; its LSB is the parity of the unbiased exponent.
    logic [EXP_W:0]   exp_sum_s;
    logic             odd_s;
    logic [MAN_W:0]   sig_s;
    logic [RADW-1:0]  rad_init_s;
    assign exp_sum_s  = {1'b0, op_exp_s} + {1'b0, BIAS_V};
    assign odd_s      = exp_sum_s[0];
    assign sig_s      = {1'b1, op_frac_s};
    assign rad_init_s = odd_s ? {sig_s, {(RW+1){1'b0}}} : {1'b0, sig_s, {RW{1'b0}}};

    // Remainder stays non-negative, so the trial compare is the sign of the signed difference.
    logic [PRW+1:0] shifted_s;
    logic [PRW-1:0] trial_s;
    logic           ge_s;
    logic [PRW-1:0] rem_nxt_s;

    // One restoring iteration: bring down two radicand bits and try root*4+1
    always_comb begin
        shifted_s = {rem_r, rad_r[RADW-1:RADW-2]};
        trial_s   = {root_r, 2'b01};
        ge_s      = (shifted_s >= {2'b00, trial_s});
        if (ge_s) begin
            rem_nxt_s = shifted_s[PRW-1:0] - trial_s;
        end else begin
            rem_nxt_s = shifted_s[PRW-1:0];
        end
    end

    logic             guard_s;
    logic             sticky_s;
    logic             inc_s;
    logic [MAN_W+1:0] sum_s;
    logic [MAN_W-1:0] frac_s;
    logic [EXP_W-1:0] exp_out_s;
    logic [XLEN-1:0]  rnd_res_s;
    logic             nx_s;

    // Round the root using guard, sticky and LSB under the active rounding mode
    always_comb begin
        guard_s  = root_r[0];
        sticky_s = |rem_r;
        case (rm_s)
            3'b000:         inc_s = guard_s & (sticky_s | root_r[1]);
            3'b001, 3'b010: inc_s = 1'b0;
            3'b011:         inc_s = guard_s | sticky_s;
            3'b100:         inc_s = guard_s;
            default:        inc_s = 1'b0;
        endcase
        sum_s = {1'b0, root_r[RW-1:1]} + {{(MAN_W+1){1'b0}}, inc_s};
        if (sum_s[MAN_W+1]) begin
            frac_s    = sum_s[MAN_W:1];
            exp_out_s = exp_r + {{(EXP_W-1){1'b0}}, 1'b1};
        end else begin
            frac_s    = sum_s[MAN_W-1:0];
            exp_out_s = exp_r;
        end
        rnd_res_s = {1'b0, exp_out_s, frac_s};
        nx_s      = guard_s | sticky_s;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r    <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= {XLEN{1'b0}};
            out_tag    <= {TAG_W{1'b0}};
            out_flags  <= 2'b00;
            rad_r      <= {RADW{1'b0}};
            rem_r      <= {PRW{1'b0}};
            root_r     <= {RW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            exp_r      <= {EXP_W{1'b0}};
            tag_r      <= {TAG_W{1'b0}};
`ifdef FP_SQRT_RM_EN
            rm_r       <= 3'b000;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        tag_r    <= in_tag;
                        in_ready <= 1'b0;
`ifdef FP_SQRT_RM_EN
                        rm_r     <= in_rm;
`endif
                        if (spec_s) begin
                            out_result <= spec_res_s;
                            out_flags  <= spec_flags_s;
                            out_tag    <= in_tag;
                            out_valid  <= 1'b1;
                            state_r    <= S_DONE;
                        end else begin
                            rad_r   <= rad_init_s;
                            rem_r   <= {PRW{1'b0}};
                            root_r  <= {RW{1'b0}};
                            cnt_r   <= {CW{1'b0}};
                            exp_r   <= exp_sum_s[EXP_W:1];
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rad_r  <= {rad_r[RADW-3:0], 2'b00};
                    rem_r  <= rem_nxt_s;
                    root_r <= {root_r[RW-2:0], ge_s};
                    if (cnt_r == LAST_CNT) begin
                        state_r <= S_ROUND;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_ROUND: begin
                    out_result <= rnd_res_s;
                    out_flags  <= {1'b0, nx_s};
                    out_tag    <= tag_r;
                    out_valid  <= 1'b1;
                    state_r    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed, table-driven bench for fp_sqrt_iter (default parameters), plus
// handshake, backpressure, flush and reset sequences.
module tb_fp_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_operand = 32'h0;
    logic [5:0]  in_tag = 6'h0;
    logic [2:0]  in_rm = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [1:0]  out_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_sqrt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_operand (in_operand),
        .in_tag     (in_tag),
`ifdef FP_SQRT_RM_EN
        .in_rm      (in_rm),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    typedef struct {
        logic [31:0] op;
        logic [5:0]  tag;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [1:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation with out_ready high and measure accept-to-valid latency
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        check($sformatf("in_ready_before[%0d]", idx), {31'b0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_operand = v.op;
        in_tag     = v.tag;
        in_rm      = v.rm;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency[%0d]", idx), lat, v.lat);
        check($sformatf("result[%0d]", idx), out_result, v.res);
        check($sformatf("flags[%0d]", idx), {30'b0, out_flags}, {30'b0, v.flags});
        check($sformatf("tag[%0d]", idx), {26'b0, out_tag}, {26'b0, v.tag});
        @(posedge clk);
        #1;
        check($sformatf("popped_valid[%0d]", idx), {31'b0, out_valid}, 32'd0);
        check($sformatf("popped_ready[%0d]", idx), {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] hold_res;
        logic [5:0]  hold_tag;
        logic [1:0]  hold_flags;
        logic [31:0] bb_ops[3];
        logic [5:0]  bb_tags[3];
        logic [31:0] bb_res[3];
        int idx;
        int got;
        int seen;

        vecs.push_back('{32'h41100000, 6'd1,  3'b000, 32'h40400000, 2'b00, 27});
        vecs.push_back('{32'h40000000, 6'd2,  3'b000, 32'h3FB504F3, 2'b01, 27});
        vecs.push_back('{32'h40800000, 6'd3,  3'b000, 32'h40000000, 2'b00, 27});
        vecs.push_back('{32'hBF800000, 6'd4,  3'b000, 32'h7FC00000, 2'b10, 1});
        vecs.push_back('{32'h80000000, 6'd5,  3'b000, 32'h80000000, 2'b00, 1});
        vecs.push_back('{32'h7F800000, 6'd6,  3'b000, 32'h7F800000, 2'b00, 1});
        vecs.push_back('{32'h7F800001, 6'd7,  3'b000, 32'h7FC00000, 2'b10, 1});
        vecs.push_back('{32'h7FC00001, 6'd8,  3'b000, 32'h7FC00000, 2'b00, 1});
        vecs.push_back('{32'hFF800000, 6'd9,  3'b000, 32'h7FC00000, 2'b10, 1});
        vecs.push_back('{32'h00000001, 6'd10, 3'b000, 32'h00000000, 2'b00, 1});
        vecs.push_back('{32'h80400000, 6'd11, 3'b000, 32'h80000000, 2'b00, 1});
        vecs.push_back('{32'h3F800000, 6'd12, 3'b000, 32'h3F800000, 2'b00, 27});
        vecs.push_back('{32'h3E800000, 6'd13, 3'b000, 32'h3F000000, 2'b00, 27});
        vecs.push_back('{32'h3F000000, 6'd14, 3'b000, 32'h3F3504F3, 2'b01, 27});
        vecs.push_back('{32'h00800000, 6'd15, 3'b000, 32'h20000000, 2'b00, 27});
        vecs.push_back('{32'h7F7FFFFF, 6'd16, 3'b000, 32'h5F7FFFFF, 2'b01, 27});
`ifdef FP_SQRT_RM_EN
        vecs.push_back('{32'h40000000, 6'd17, 3'b011, 32'h3FB504F4, 2'b01, 27});
        vecs.push_back('{32'h40000000, 6'd18, 3'b001, 32'h3FB504F3, 2'b01, 27});
        vecs.push_back('{32'h40000000, 6'd19, 3'b010, 32'h3FB504F3, 2'b01, 27});
        vecs.push_back('{32'h40000000, 6'd20, 3'b100, 32'h3FB504F3, 2'b01, 27});
        vecs.push_back('{32'h40000000, 6'd21, 3'b101, 32'h7FC00000, 2'b10, 1});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_tag", {26'b0, out_tag}, 32'd0);
        check("rst_flags", {30'b0, out_flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: hold the result in DONE for 10 cycles
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_operand = 32'h41100000;
        in_tag     = 6'd40;
        in_rm      = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        hold_res   = out_result;
        hold_tag   = out_tag;
        hold_flags = out_flags;
        check("bp_result", hold_res, 32'h40400000);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_result", out_result, 32'h40400000);
            check("bp_hold_tag", {26'b0, out_tag}, {26'b0, hold_tag});
            check("bp_hold_flags", {30'b0, out_flags}, {30'b0, hold_flags});
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("bp_tag_value", {26'b0, hold_tag}, 32'd40);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_pop_valid", {31'b0, out_valid}, 32'd0);
        check("bp_pop_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back: in_valid held high, results must return in order with tags
        bb_ops[0] = 32'h40800000; bb_tags[0] = 6'd21; bb_res[0] = 32'h40000000;
        bb_ops[1] = 32'hBF800000; bb_tags[1] = 6'd22; bb_res[1] = 32'h7FC00000;
        bb_ops[2] = 32'h3F000000; bb_tags[2] = 6'd23; bb_res[2] = 32'h3F3504F3;
        idx = 0;
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got < 3; c++) begin
            @(negedge clk);
            if (idx < 3) begin
                in_valid   = 1'b1;
                in_operand = bb_ops[idx];
                in_tag     = bb_tags[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                check($sformatf("bb_result[%0d]", got), out_result, bb_res[got]);
                check($sformatf("bb_tag[%0d]", got), {26'b0, out_tag}, {26'b0, bb_tags[got]});
                got++;
            end
            if (in_valid && in_ready) begin
                idx++;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        check("bb_count", got, 3);

        // Flush five cycles into CALC
        @(negedge clk);
        in_valid   = 1'b1;
        in_operand = 32'h41100000;
        in_tag     = 6'd33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // Flush in IDLE masks in_valid
        @(negedge clk);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_operand = 32'hBF800000;
        in_tag     = 6'd34;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("flush_idle_no_valid", {31'b0, out_valid}, 32'd0);

        // Flush discards an unpopped DONE result
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_operand = 32'h7F800000;
        in_tag     = 6'd35;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_pre_flush_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_valid", {31'b0, out_valid}, 32'd0);
        check("done_flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

        v = '{32'h3F800000, 6'd36, 3'b000, 32'h3F800000, 2'b00, 27};
        run_vec(v, 100);

        // Reset mid-CALC
        @(negedge clk);
        in_valid   = 1'b1;
        in_operand = 32'h40000000;
        in_tag     = 6'd44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", out_result, 32'd0);
        check("midrst_tag", {26'b0, out_tag}, 32'd0);
        check("midrst_flags", {30'b0, out_flags}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Multi-cycle, handshaked IEEE-754 square-root unit for the F-extension execution cluster. It is the parametrised successor to the combinational Newton-iteration sqrt.
- Produces one root bit per cycle using a restoring digit-recurrence.
- Correctly rounds the result and raises RISC-V NV/NX flags.
- Carries an issue tag so the out-of-order back end can match results, and supports pipeline flush.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width. XLEN = 1+EXP_W+MAN_W.
- TAG_W, 6, width of the ROB/issue tag carried through.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill any in-flight operation
- in_valid  in  1  operand valid
- in_ready  out  1  unit can accept
- in_operand  in  XLEN  IEEE operand
- in_tag  in  TAG_W  issue tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  rounded root
- out_tag  out  TAG_W  tag of result
- out_flags  out  2  {NV, NX}

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; in_ready=1; out_valid=0; out_result, out_tag, out_flags all 0.
- rst has top priority. flush comes next: the following cycle the state is IDLE and out_valid=0, and any result is discarded, including a DONE result not yet popped. If flush is high while in IDLE, in_valid is ignored.
- Accept when in_valid && in_ready. in_ready = (state==IDLE). Operand and tag are registered on accept.
- States:
  - IDLE: on accept, go to DONE if the operand is special, otherwise to CALC.
  - CALC: runs MAN_W+2 cycles, one root bit per cycle, counted by a cycle counter. Then go to ROUND.
  - ROUND: one cycle, then DONE.
  - DONE: out_valid=1, outputs held stable. When out_ready=1, go to IDLE. No same-cycle re-accept; in_ready rises the next cycle.
- Latency, accept edge to out_valid:
  - Normal operand: MAN_W+4 cycles (27 at defaults).
  - Special operand: 1 cycle.
- Special cases (sign s, exponent E, fraction F):
  - NaN input: 0x7FC00000-style canonical qNaN (sign 0, MSB of fraction set). NV=1 only for a signalling NaN.
  - Negative nonzero input, including -inf: canonical qNaN, NV=1.
  - ±0: passes through with sign preserved, flags 0.
  - Subnormal input: treated as ±0 (flush-to-zero), result ±0, flags 0.
  - +inf: +inf, flags 0.
- Normal path:
  - Unbiased exponent e = E - bias, where bias = 2^(EXP_W-1)-1.
  - Significand = {1,F}.
  - If e is odd, shift the significand left 1 and use e-1.
  - Radicand is placed in a 2*(MAN_W+2)-bit register, giving root R of MAN_W+2 bits: 1 integer, MAN_W fraction, 1 guard.
  - Sticky = (final partial remainder != 0).
  - Result exponent = e/2 + bias (arithmetic, e even).
- Rounding: round-to-nearest-even on guard/sticky/LSB.
  - A mantissa carry-out increments the exponent and zeroes the fraction.
  - NX = guard | sticky.
  - Result sign is always 0 on the normal path.
- The partial remainder needs MAN_W+4 bits signed; no truncation is allowed.

Optional Feature:
- Macro: FP_SQRT_RM_EN.
- When defined, add input in_rm[2:0], registered on accept. Rounding follows the RISC-V encodings:
  - RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100. RDN behaves as RTZ because the result is positive.
  - Encodings 101–111 return the canonical qNaN with NV=1 through the special path, 1-cycle latency.
- When not defined, the port is absent and rounding is RNE only.

Test Plan:
- 9.0 (0x41100000), out_ready=1 → out_result=0x40400000 (odd-exponent path), flags=00, out_valid exactly 27 cycles after accept, tag echoed.
- 2.0 (0x40000000) → 0x3FB504F3, NX=1, NV=0. Then 4.0 (0x40800000) → 0x40000000, NX=0.
- -1.0 (0xBF800000) → 0x7FC00000, NV=1, out_valid 1 cycle after accept. -0 (0x80000000) → 0x80000000, flags 00. +inf (0x7F800000) → 0x7F800000. sNaN 0x7F800001 → 0x7FC00000, NV=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, result, tag and flags stable, in_ready=0. Pulse out_ready → in_ready=1 the next cycle. Back-to-back ops return in order with their tags.
- Flush at CALC cycle 5 → next cycle state IDLE, in_ready=1, and no out_valid ever for that tag. Repeat with rst mid-CALC → all outputs at their reset values.
- With FP_SQRT_RM_EN: 2.0 under RUP → 0x3FB504F4, under RTZ → 0x3FB504F3. rm=101 → 0x7FC00000, NV=1.
